// File: rtl/serial_pattern_rx.sv
// Serial-to-parallel receiver: oversamples an external bit clock, assembles
// MSB-first words and reports ready/match/overrun status to the register file.
module serial_pattern_rx #(
  parameter int                   BUS_WIDTH      = 8,
  parameter logic [BUS_WIDTH-1:0] PATTERN_RESET  = 8'hA5,
  parameter int                   TIMEOUT_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 ser_clk_in,
  input  logic                 ser_data_in,
  input  logic                 ack,
  input  logic                 pat_we,
  input  logic [BUS_WIDTH-1:0] pat_data,
  output logic [BUS_WIDTH-1:0] rx_data,
  output logic                 ready_in,
  output logic                 pattern_match,
  output logic                 overrun
);

  localparam int CNT_W = (BUS_WIDTH > 2) ? $clog2(BUS_WIDTH) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_WIDTH - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic ser_clk_p0, ser_clk_p1, ser_clk_p2;
  logic ser_dat_p0, ser_dat_p1;
  logic vld_p3, bit_p3;

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [TMO_W-1:0]       tmo_cnt;
  logic [BUS_WIDTH-2:0]   shift_q;
  logic [BUS_WIDTH-1:0]   pattern;
  logic [BUS_WIDTH-1:0]   word_next;
  logic                   word_done;

  // p0..p2: two-flop synchronisers plus the edge-detect history flop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ser_clk_p0 <= 1'b0;
      ser_clk_p1 <= 1'b0;
      ser_clk_p2 <= 1'b0;
      ser_dat_p0 <= 1'b0;
      ser_dat_p1 <= 1'b0;
      vld_p3     <= 1'b0;
      bit_p3     <= 1'b0;
    end else begin
      ser_clk_p0 <= ser_clk_in;
      ser_clk_p1 <= ser_clk_p0;
      ser_clk_p2 <= ser_clk_p1;
      ser_dat_p0 <= ser_data_in;
      ser_dat_p1 <= ser_dat_p0;
      vld_p3     <= ser_clk_p1 & ~ser_clk_p2;
      bit_p3     <= ser_dat_p1;
    end
  end

  always_comb begin
    word_next = {shift_q, bit_p3};
    word_done = vld_p3 && (state == SHIFT) && (bit_cnt == CNT_LAST);
  end

  // p3 -> outputs: word assembly, idle timeout and status flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      tmo_cnt       <= '0;
      shift_q       <= '0;
      pattern       <= PATTERN_RESET;
      rx_data       <= '0;
      ready_in      <= 1'b0;
      pattern_match <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (vld_p3) begin
            shift_q <= (BUS_WIDTH-1)'(bit_p3);
            bit_cnt <= CNT_W'(1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (vld_p3) begin
            tmo_cnt <= '0;
            if (word_done) begin
              shift_q <= '0;
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              shift_q <= word_next[BUS_WIDTH-2:0];
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (tmo_cnt == TMO_LAST) begin
            // stalled sender: drop the partial word so stale bits never leak
            shift_q <= '0;
            bit_cnt <= '0;
            tmo_cnt <= '0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (word_done) begin
        if (!ready_in || ack) begin
          rx_data       <= word_next;
          ready_in      <= 1'b1;
          pattern_match <= (word_next == pattern);
          if (ack) overrun <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (ack) begin
        ready_in      <= 1'b0;
        pattern_match <= 1'b0;
        overrun       <= 1'b0;
      end

      if (pat_we) pattern <= pat_data;
    end
  end

endmodule

// File: tb/tb_serial_pattern_rx.sv
// Bench for serial_pattern_rx: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a behavioural model.
module tb_serial_pattern_rx;

  localparam int W = 8;
  localparam int T = 64;

  logic         clock       = 1'b0;
  logic         reset_n     = 1'b0;
  logic         ser_clk_in  = 1'b0;
  logic         ser_data_in = 1'b0;
  logic         ack         = 1'b0;
  logic         pat_we      = 1'b0;
  logic [W-1:0] pat_data    = '0;
  logic [W-1:0] rx_data;
  logic         ready_in;
  logic         pattern_match;
  logic         overrun;

  int           checks   = 0;
  int           failures = 0;
  bit           rnd_mode = 1'b0;
  logic [W-1:0] last_pat = 8'hA5;

  serial_pattern_rx #(
    .BUS_WIDTH      (W),
    .PATTERN_RESET  (8'hA5),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ser_clk_in    (ser_clk_in),
    .ser_data_in   (ser_data_in),
    .ack           (ack),
    .pat_we        (pat_we),
    .pat_data      (pat_data),
    .rx_data       (rx_data),
    .ready_in      (ready_in),
    .pattern_match (pattern_match),
    .overrun       (overrun)
  );

  always #5 clock = ~clock;

  // Behavioural model: a serial-clock rise sampled at cycle k is acted on at
  // cycle k+3; bits are accumulated arithmetically and counted up to W.
  typedef struct packed {
    logic [3:0]   hc;
    logic [3:0]   hd;
    logic [W-1:0] acc;
    logic [7:0]   nbits;
    logic [31:0]  idle;
    logic [W-1:0] rx;
    logic         ready;
    logic         match;
    logic         ovr;
    logic [W-1:0] pat;
  } mst_t;

  function automatic mst_t model_reset();
    mst_t r;
    r     = '0;
    r.pat = 8'hA5;
    return r;
  endfunction

  function automatic mst_t model_step(mst_t s, logic sc, logic sd, logic a,
                                      logic we, logic [W-1:0] pd);
    mst_t         n;
    logic         ev, b, done;
    logic [W-1:0] word;
    n    = s;
    done = 1'b0;
    word = '0;
    ev   = s.hc[2] & ~s.hc[3];
    b    = s.hd[2];
    n.hc = {s.hc[2:0], sc};
    n.hd = {s.hd[2:0], sd};
    if (ev) begin
      n.acc   = W'((s.acc * 2) + b);
      n.nbits = s.nbits + 8'd1;
      n.idle  = 0;
      if (n.nbits == W) begin
        done    = 1'b1;
        word    = n.acc;
        n.acc   = '0;
        n.nbits = '0;
      end
    end else if (s.nbits != 0) begin
      n.idle = s.idle + 1;
      if (n.idle == T) begin
        n.acc   = '0;
        n.nbits = '0;
        n.idle  = 0;
      end
    end
    if (done) begin
      if (!s.ready || a) begin
        n.rx    = word;
        n.ready = 1'b1;
        n.match = (word == s.pat);
        if (a) n.ovr = 1'b0;
      end else begin
        n.ovr = 1'b1;
      end
    end else if (a) begin
      n.ready = 1'b0;
      n.match = 1'b0;
      n.ovr   = 1'b0;
    end
    if (we) n.pat = pd;
    return n;
  endfunction

  mst_t m;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m <= model_reset();
    else          m <= model_step(m, ser_clk_in, ser_data_in, ack, pat_we, pat_data);
  end

  // Every cycle: compare DUT against the model (all zeros while in reset).
  task automatic tick();
    logic [W+2:0] got, exp;
    @(posedge clock);
    #1;
    got = {rx_data, ready_in, pattern_match, overrun};
    exp = reset_n ? {m.rx, m.ready, m.match, m.ovr} : '0;
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL cycle_model t=%0t got rx=%h rdy=%b mat=%b ovr=%b want rx=%h rdy=%b mat=%b ovr=%b",
               $time, got[W+2:3], got[2], got[1], got[0], exp[W+2:3], exp[2], exp[1], exp[0]);
    end
    if (rnd_mode) begin
      ack      = ($urandom_range(0, 15) == 0);
      pat_we   = ($urandom_range(0, 31) == 0);
      pat_data = W'($urandom);
      if (pat_we) last_pat = pat_data;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int half);
    ser_clk_in  = 1'b0;
    ser_data_in = b;
    repeat (half) tick();
    ser_clk_in = 1'b1;
    repeat (half) tick();
  endtask

  task automatic send_word(input logic [W-1:0] w, input int half);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i], half);
  endtask

  // Last bit sent by hand so ack can coincide with the final edge.
  task automatic send_word_ack_last(input logic [W-1:0] w);
    for (int i = W - 1; i >= 1; i--) send_bit(w[i], 4);
    ser_clk_in  = 1'b0;
    ser_data_in = w[0];
    repeat (4) tick();
    ser_clk_in = 1'b1;
    repeat (3) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w;
    int           half;
    int           n;

    // Reset state
    repeat (3) tick();
    chk("reset_rx", 32'(rx_data), 32'h0);
    chk("reset_flags", 32'({ready_in, pattern_match, overrun}), 32'h0);
    reset_n = 1'b1;
    tick();

    // A5 against the reset pattern, with exact latency from the 8th rise
    w = 8'hA5;
    for (int i = W - 1; i >= 1; i--) send_bit(w[i], 4);
    ser_clk_in  = 1'b0;
    ser_data_in = w[0];
    repeat (4) tick();
    ser_clk_in = 1'b1;
    repeat (3) tick();
    chk("lat_not_yet", 32'(ready_in), 32'h0);
    tick();
    chk("a5_ready", 32'(ready_in), 32'h1);
    chk("a5_rx", 32'(rx_data), 32'hA5);
    chk("a5_match", 32'(pattern_match), 32'h1);
    chk("a5_ovr", 32'(overrun), 32'h0);
    repeat (3) tick();

    // Pattern write, match, ack, mismatch
    pulse_ack();
    chk("ack_clears", 32'({ready_in, pattern_match, overrun}), 32'h0);
    pat_data = 8'h3C;
    pat_we   = 1'b1;
    tick();
    pat_we = 1'b0;
    send_word(8'h3C, 4);
    chk("3c_match", 32'({rx_data, ready_in, pattern_match}), {22'h0, 8'h3C, 2'b11});
    pulse_ack();
    chk("3c_acked", 32'({ready_in, pattern_match, overrun}), 32'h0);
    send_word(8'h3D, 4);
    chk("3d_nomatch", 32'({rx_data, ready_in, pattern_match}), {22'h0, 8'h3D, 2'b10});

    // Overrun
    pulse_ack();
    send_word(8'h11, 4);
    chk("11_rx", 32'({rx_data, ready_in}), {23'h0, 8'h11, 1'b1});
    send_word(8'h22, 4);
    chk("ovr_rx_held", 32'(rx_data), 32'h11);
    chk("ovr_flags", 32'({ready_in, overrun}), 32'h3);
    pulse_ack();
    chk("ovr_acked", 32'({ready_in, pattern_match, overrun}), 32'h0);
    chk("ovr_acked_rx", 32'(rx_data), 32'h11);

    // Timeout discards a stalled partial word
    send_bit(1'b1, 4);
    send_bit(1'b1, 4);
    send_bit(1'b1, 4);
    repeat (T + 5) tick();
    chk("tmo_no_flag", 32'(ready_in), 32'h0);
    send_word(8'hF0, 4);
    chk("tmo_f0", 32'({rx_data, ready_in}), {23'h0, 8'hF0, 1'b1});

    // ack in the cycle of the final edge while ready_in is set
    send_word_ack_last(8'h55);
    chk("ackfin_rx", 32'(rx_data), 32'h55);
    chk("ackfin_flags", 32'({ready_in, pattern_match, overrun}), 32'h4);

    // Reset mid-word
    pulse_ack();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 4);
    ser_clk_in = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_outs", 32'({rx_data, ready_in, pattern_match, overrun}), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    send_word(8'hC3, 4);
    chk("c3_after_rst", 32'({rx_data, ready_in, pattern_match}), {22'h0, 8'hC3, 2'b10});
    pulse_ack();
    send_word(8'hA5, 4);
    chk("pat_reset_a5", 32'(pattern_match), 32'h1);

    // Randomized traffic: random words, phases, acks, pattern writes, stalls
    pulse_ack();
    last_pat = 8'hA5;
    rnd_mode = 1'b1;
    for (int it = 0; it < 60; it++) begin
      half = $urandom_range(2, 5);
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(1, W - 1);
        for (int b = 0; b < n; b++) send_bit(1'($urandom), half);
        repeat ($urandom_range(T - 6, T + 4)) tick();
      end else begin
        w = ($urandom_range(0, 3) == 0) ? last_pat : W'($urandom);
        send_word(w, half);
      end
    end
    rnd_mode = 1'b0;
    ack      = 1'b0;
    pat_we   = 1'b0;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
